hilo_unit: RTL and testbench

- Owns the architectural HI/LO registers of the MIPS core and sequences the multi-cycle multiply/divide units.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute, launches the divider or multiplier, and holds their operands stable.
- Captures results into HI/LO and serves MFHI/MFLO reads.
- Drives the pipeline stall while a result is outstanding.

---
 rtl/hilo_pkg.sv | 37 +++
 rtl/hilo_launch.sv | 47 ++++
 rtl/hilo_unit.sv | 164 ++++++++++++++++
 tb/tb_hilo_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// ---------------------------------------------------------------------------
// hilo_pkg
// Shared definitions for the HI/LO register unit of the MIPS core:
//   DATA_W  : default operand / HI / LO width
//   op_e    : HI/LO-class operation codes presented by execute
//   state_e : sequencing states of hilo_unit
//   is_div_op / is_mul_op : operation class decode helpers
// ---------------------------------------------------------------------------
package hilo_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_RUN = 2'd1,
      MUL_RUN = 2'd2,
      COOL    = 2'd3
   } state_e;

   function automatic logic is_div_op(input op_e op);
      return (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_mul_op(input op_e op);
      return (op == MULT) || (op == MULTU);
   endfunction

endpackage

// File: rtl/hilo_launch.sv
// ---------------------------------------------------------------------------
// hilo_launch
// Operand latch and valid_in generator for one multi-cycle arithmetic unit
// (instantiated once for the divider and once for the multiplier).
// Ports:
//   clk, reset_n      : core clock, asynchronous active-low reset
//   launch            : accept a new operation (captures sign/operands)
//   sign_in, a_in, b_in : operation sign and operands from execute
//   done              : unit reported completion while running
//   valid_in          : start/hold to the unit, high for the whole operation
//   sign, src_a, src_b : latched sign and operands, stable until next launch
// valid_in falls on the edge where completion is sampled, so the unit sees
// it low during the following cool-down cycle and can re-arm.
// ---------------------------------------------------------------------------
module hilo_launch #(
   parameter int DATA_W = hilo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              launch,
   input  logic              sign_in,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              done,
   output logic              valid_in,
   output logic              sign,
   output logic [DATA_W-1:0] src_a,
   output logic [DATA_W-1:0] src_b
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_in <= 1'b0;
         sign     <= 1'b0;
         src_a    <= '0;
         src_b    <= '0;
      end else if (launch) begin
         valid_in <= 1'b1;
         sign     <= sign_in;
         src_a    <= a_in;
         src_b    <= b_in;
      end else if (done) begin
         valid_in <= 1'b0;
      end
   end

endmodule

// File: rtl/hilo_unit.sv
// ---------------------------------------------------------------------------
// hilo_unit
// Architectural HI/LO registers plus sequencing of the external multi-cycle
// divider and multiplier.
// Ports:
//   clk, reset_n                 : core clock, asynchronous active-low reset
//   op_valid/op_code/op_a/op_b   : HI/LO-class op from execute (rs, rt)
//   op_ready                     : op accepted this cycle (IDLE only)
//   rd_en/rd_sel/rd_data         : MFHI (rd_sel=0) / MFLO (rd_sel=1) read
//   stall                        : freeze upstream pipeline
//   div_*                        : divider handshake, operands and results
//   mul_*                        : multiplier handshake, operands and results
//   hi_q, lo_q                   : current HI / LO, for debug
// Optional build macro HILO_BYPASS_EN: a read pending in the completion
// cycle is served straight from the unit result and stall drops that cycle.
// Without it the read waits and is served from HI/LO one cycle later.
// ---------------------------------------------------------------------------
module hilo_unit #(
   parameter int DATA_W = hilo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              op_valid,
   input  logic [2:0]        op_code,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              op_ready,
   input  logic              rd_en,
   input  logic              rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic              stall,
   output logic              div_valid_in,
   output logic              div_sign,
   output logic [DATA_W-1:0] div_src_a,
   output logic [DATA_W-1:0] div_src_b,
   input  logic              div_valid_out,
   input  logic [DATA_W-1:0] div_hi,
   input  logic [DATA_W-1:0] div_lo,
   output logic              mul_valid_in,
   output logic              mul_sign,
   output logic [DATA_W-1:0] mul_src_a,
   output logic [DATA_W-1:0] mul_src_b,
   input  logic              mul_valid_out,
   input  logic [DATA_W-1:0] mul_hi,
   input  logic [DATA_W-1:0] mul_lo,
   output logic [DATA_W-1:0] hi_q,
   output logic [DATA_W-1:0] lo_q
);

   import hilo_pkg::*;

   state_e state, state_nx;
   op_e    op;
   logic   accept;
   logic   div_launch, mul_launch;
   logic   div_done, mul_done;
   logic   rd_busy;

   assign op     = op_e'(op_code);
   assign accept = (state == IDLE) && op_valid;

   // A divide by zero is accepted but never reaches the divider.
   assign div_launch = accept && is_div_op(op) && (op_b != '0);
   assign mul_launch = accept && is_mul_op(op);

   // Completion is only honoured while running; a lingering valid_out in
   // COOL or IDLE is ignored.
   assign div_done = (state == DIV_RUN) && div_valid_out;
   assign mul_done = (state == MUL_RUN) && mul_valid_out;

   hilo_launch #(.DATA_W(DATA_W)) u_div_launch (
      .clk      (clk),
      .reset_n  (reset_n),
      .launch   (div_launch),
      .sign_in  (op == DIV),
      .a_in     (op_a),
      .b_in     (op_b),
      .done     (div_done),
      .valid_in (div_valid_in),
      .sign     (div_sign),
      .src_a    (div_src_a),
      .src_b    (div_src_b)
   );

   hilo_launch #(.DATA_W(DATA_W)) u_mul_launch (
      .clk      (clk),
      .reset_n  (reset_n),
      .launch   (mul_launch),
      .sign_in  (op == MULT),
      .a_in     (op_a),
      .b_in     (op_b),
      .done     (mul_done),
      .valid_in (mul_valid_in),
      .sign     (mul_sign),
      .src_a    (mul_src_a),
      .src_b    (mul_src_b)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      op_ready = 1'b0;
      case (state)
         IDLE: begin
            op_ready = op_valid;
            if (div_launch) begin
               state_nx = DIV_RUN;
            end else if (mul_launch) begin
               state_nx = MUL_RUN;
            end
         end
         DIV_RUN: if (div_valid_out) state_nx = COOL;
         MUL_RUN: if (mul_valid_out) state_nx = COOL;
         COOL:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The divider returns the quotient on its hi port; MIPS keeps the
   // quotient in LO and the remainder in HI, hence the swap. MTHI/MTLO only
   // land when accepted in IDLE, so they can never clobber a pending result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (div_done) begin
         lo_q <= div_hi;
         hi_q <= div_lo;
      end else if (mul_done) begin
         hi_q <= mul_hi;
         lo_q <= mul_lo;
      end else if (accept) begin
         if (op == MTHI) hi_q <= op_a;
         if (op == MTLO) lo_q <= op_a;
      end
   end

`ifdef HILO_BYPASS_EN
   assign rd_busy = ((state == DIV_RUN) && !div_valid_out) ||
                    ((state == MUL_RUN) && !mul_valid_out);

   always_comb begin
      rd_data = rd_sel ? lo_q : hi_q;
      if (div_done) begin
         rd_data = rd_sel ? div_hi : div_lo;
      end else if (mul_done) begin
         rd_data = rd_sel ? mul_lo : mul_hi;
      end
   end
`else
   assign rd_busy = (state == DIV_RUN) || (state == MUL_RUN);
   assign rd_data = rd_sel ? lo_q : hi_q;
`endif

   assign stall = (op_valid && !op_ready) || (rd_en && rd_busy);

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

   localparam logic [2:0] C_MULT  = 3'd0;
   localparam logic [2:0] C_MULTU = 3'd1;
   localparam logic [2:0] C_DIV   = 3'd2;
   localparam logic [2:0] C_DIVU  = 3'd3;
   localparam logic [2:0] C_MTHI  = 3'd4;
   localparam logic [2:0] C_MTLO  = 3'd5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = 3'd0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        op_ready;
   logic        rd_en = 1'b0, rd_sel = 1'b0;
   logic [31:0] rd_data;
   logic        stall;
   logic        div_valid_in, div_sign;
   logic [31:0] div_src_a, div_src_b;
   logic        div_valid_out = 1'b0;
   logic [31:0] div_hi = '0, div_lo = '0;
   logic        mul_valid_in, mul_sign;
   logic [31:0] mul_src_a, mul_src_b;
   logic        mul_valid_out = 1'b0;
   logic [31:0] mul_hi = '0, mul_lo = '0;
   logic [31:0] hi_q, lo_q;

   int tests = 0;
   int fails = 0;

   hilo_unit #(.DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
      .op_ready(op_ready),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data), .stall(stall),
      .div_valid_in(div_valid_in), .div_sign(div_sign),
      .div_src_a(div_src_a), .div_src_b(div_src_b),
      .div_valid_out(div_valid_out), .div_hi(div_hi), .div_lo(div_lo),
      .mul_valid_in(mul_valid_in), .mul_sign(mul_sign),
      .mul_src_a(mul_src_a), .mul_src_b(mul_src_b),
      .mul_valid_out(mul_valid_out), .mul_hi(mul_hi), .mul_lo(mul_lo),
      .hi_q(hi_q), .lo_q(lo_q)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Present one op for a single IDLE cycle; returns at the next negedge.
   task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input string nm);
      op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
      #1;
      tests++;
      if (op_ready !== 1'b1) begin
         fails++; $display("FAIL %s_ready: got %b required 1", nm, op_ready);
      end
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if ({hi_q, lo_q} !== 64'd0) begin
         fails++; $display("FAIL reset_hilo: got %h_%h required 0_0", hi_q, lo_q);
      end
      tests++;
      if ({div_valid_in, div_sign, mul_valid_in, mul_sign, stall, op_ready} !== 6'b0) begin
         fails++; $display("FAIL reset_ctrl: got %b required 000000",
                           {div_valid_in, div_sign, mul_valid_in, mul_sign, stall, op_ready});
      end
      tests++;
      if ({div_src_a, div_src_b, mul_src_a, mul_src_b} !== 128'd0) begin
         fails++; $display("FAIL reset_src: got %h %h %h %h required all 0",
                           div_src_a, div_src_b, mul_src_a, mul_src_b);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_divu();
      issue(C_DIVU, 32'd100, 32'd7, "divu");
      rd_en = 1'b1; rd_sel = 1'b1;
      #1;
      tests++;
      if ({div_valid_in, div_sign, div_src_a, div_src_b, stall} !== {1'b1, 1'b0, 32'd100, 32'd7, 1'b1}) begin
         fails++; $display("FAIL divu_launch: got vin=%b sign=%b a=%0d b=%0d stall=%b required 1 0 100 7 1",
                           div_valid_in, div_sign, div_src_a, div_src_b, stall);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         tests++;
         if ({div_valid_in, stall, div_src_a} !== {1'b1, 1'b1, 32'd100}) begin
            fails++; $display("FAIL divu_run%0d: got vin=%b stall=%b a=%0d required 1 1 100",
                              i, div_valid_in, stall, div_src_a);
         end
      end
      @(negedge clk);
      div_valid_out = 1'b1; div_hi = 32'd14; div_lo = 32'd2;
      #1;
`ifdef HILO_BYPASS_EN
      tests++;
      if ({stall, rd_data} !== {1'b0, 32'd14}) begin
         fails++; $display("FAIL divu_bypass: got stall=%b rd=%0d required 0 14", stall, rd_data);
      end
`else
      tests++;
      if (stall !== 1'b1) begin
         fails++; $display("FAIL divu_done_stall: got %b required 1", stall);
      end
`endif
      @(negedge clk); #1;
      tests++;
      if ({lo_q, hi_q} !== {32'd14, 32'd2}) begin
         fails++; $display("FAIL divu_result: got LO=%0d HI=%0d required LO=14 HI=2", lo_q, hi_q);
      end
      tests++;
      if ({div_valid_in, stall, rd_data} !== {1'b0, 1'b0, 32'd14}) begin
         fails++; $display("FAIL divu_cool: got vin=%b stall=%b rd=%0d required 0 0 14",
                           div_valid_in, stall, rd_data);
      end
      div_valid_out = 1'b0; rd_en = 1'b0;
      @(negedge clk); #1;
      tests++;
      if (div_valid_in !== 1'b0) begin
         fails++; $display("FAIL divu_idle_vin: got %b required 0", div_valid_in);
      end
      @(negedge clk);
   endtask

   task automatic test_div_signed();
      issue(C_DIV, 32'hFFFF_FFF9, 32'd2, "div");
      op_a = 32'h1234_5678; op_b = 32'd0;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++;
         if ({div_valid_in, div_sign, div_src_a, div_src_b} !== {1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2}) begin
            fails++; $display("FAIL div_hold%0d: got vin=%b sign=%b a=%h b=%h required 1 1 fffffff9 00000002",
                              i, div_valid_in, div_sign, div_src_a, div_src_b);
         end
         @(negedge clk);
      end
      div_valid_out = 1'b1; div_hi = 32'hFFFF_FFFD; div_lo = 32'hFFFF_FFFF;
      @(negedge clk);
      div_valid_out = 1'b0;
      #1;
      tests++;
      if ({lo_q, hi_q, div_valid_in} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
         fails++; $display("FAIL div_swap: got LO=%h HI=%h vin=%b required fffffffd ffffffff 0",
                           lo_q, hi_q, div_valid_in);
      end
      @(negedge clk);
   endtask

   task automatic test_multu();
      issue(C_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
      rd_en = 1'b1; rd_sel = 1'b1;
      #1;
      tests++;
      if ({mul_valid_in, mul_sign, mul_src_a, mul_src_b, div_valid_in, stall} !==
          {1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1}) begin
         fails++; $display("FAIL multu_launch: got vin=%b sign=%b a=%h b=%h dvin=%b stall=%b required 1 0 ffffffff 2 0 1",
                           mul_valid_in, mul_sign, mul_src_a, mul_src_b, div_valid_in, stall);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         tests++;
         if ({mul_valid_in, stall} !== 2'b11) begin
            fails++; $display("FAIL multu_run%0d: got vin=%b stall=%b required 1 1", i, mul_valid_in, stall);
         end
      end
      @(negedge clk);
      mul_valid_out = 1'b1; mul_hi = 32'd1; mul_lo = 32'hFFFF_FFFE;
      #1;
`ifdef HILO_BYPASS_EN
      tests++;
      if ({stall, rd_data} !== {1'b0, 32'hFFFF_FFFE}) begin
         fails++; $display("FAIL multu_bypass: got stall=%b rd=%h required 0 fffffffe", stall, rd_data);
      end
`else
      tests++;
      if (stall !== 1'b1) begin
         fails++; $display("FAIL multu_done_stall: got %b required 1", stall);
      end
`endif
      @(negedge clk); #1;
      tests++;
      if ({hi_q, lo_q, rd_data, mul_valid_in, stall} !== {32'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0}) begin
         fails++; $display("FAIL multu_result: got HI=%h LO=%h rd=%h vin=%b stall=%b required 1 fffffffe fffffffe 0 0",
                           hi_q, lo_q, rd_data, mul_valid_in, stall);
      end
      mul_valid_out = 1'b0; rd_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_div_zero();
      // HI=1, LO=fffffffe from the multiply.
      rd_en = 1'b1; rd_sel = 1'b0;
      op_valid = 1'b1; op_code = C_MTHI; op_a = 32'd5; op_b = 32'd0;
      #1;
      tests++;
      if ({op_ready, rd_data} !== {1'b1, 32'd1}) begin
         fails++; $display("FAIL mthi_prewrite: got ready=%b rd=%h required 1 00000001", op_ready, rd_data);
      end
      @(negedge clk);
      op_code = C_MTLO; op_a = 32'd6; rd_sel = 1'b1;
      #1;
      tests++;
      if ({hi_q, rd_data} !== {32'd5, 32'hFFFF_FFFE}) begin
         fails++; $display("FAIL mtlo_prewrite: got HI=%h rd=%h required 5 fffffffe", hi_q, rd_data);
      end
      @(negedge clk);
      op_valid = 1'b0; rd_en = 1'b0;
      issue(C_DIV, 32'd50, 32'd0, "divzero");
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if ({div_valid_in, stall, hi_q, lo_q} !== {1'b0, 1'b0, 32'd5, 32'd6}) begin
            fails++; $display("FAIL divzero%0d: got vin=%b stall=%b HI=%0d LO=%0d required 0 0 5 6",
                              i, div_valid_in, stall, hi_q, lo_q);
         end
         @(negedge clk);
      end
      issue(3'd7, 32'd77, 32'd88, "unknown");
      #1;
      tests++;
      if ({div_valid_in, mul_valid_in, hi_q, lo_q} !== {1'b0, 1'b0, 32'd5, 32'd6}) begin
         fails++; $display("FAIL unknown_op: got dvin=%b mvin=%b HI=%0d LO=%0d required 0 0 5 6",
                           div_valid_in, mul_valid_in, hi_q, lo_q);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      issue(C_DIVU, 32'd20, 32'd4, "b2b_first");
      op_valid = 1'b1; op_code = C_DIVU; op_a = 32'd30; op_b = 32'd3;
      #1;
      tests++;
      if ({op_ready, stall, div_src_a} !== {1'b0, 1'b1, 32'd20}) begin
         fails++; $display("FAIL b2b_queued: got ready=%b stall=%b a=%0d required 0 1 20", op_ready, stall, div_src_a);
      end
      repeat (2) @(negedge clk);
      div_valid_out = 1'b1; div_hi = 32'd5; div_lo = 32'd0;
      @(negedge clk);
      div_valid_out = 1'b0;
      #1;
      tests++;
      if ({div_valid_in, op_ready, stall, lo_q, div_src_a} !== {1'b0, 1'b0, 1'b1, 32'd5, 32'd20}) begin
         fails++; $display("FAIL b2b_cool: got vin=%b ready=%b stall=%b LO=%0d a=%0d required 0 0 1 5 20",
                           div_valid_in, op_ready, stall, lo_q, div_src_a);
      end
      @(negedge clk); #1;
      tests++;
      if ({op_ready, stall, div_valid_in} !== 3'b100) begin
         fails++; $display("FAIL b2b_idle: got ready=%b stall=%b vin=%b required 1 0 0", op_ready, stall, div_valid_in);
      end
      @(negedge clk);
      op_code = C_MTLO; op_a = 32'd9; op_b = 32'd0;
      #1;
      tests++;
      if ({div_valid_in, div_src_a, div_src_b, op_ready, stall} !== {1'b1, 32'd30, 32'd3, 1'b0, 1'b1}) begin
         fails++; $display("FAIL b2b_second: got vin=%b a=%0d b=%0d ready=%b stall=%b required 1 30 3 0 1",
                           div_valid_in, div_src_a, div_src_b, op_ready, stall);
      end
      repeat (2) @(negedge clk);
      div_valid_out = 1'b1; div_hi = 32'd10; div_lo = 32'd0;
      @(negedge clk);
      div_valid_out = 1'b0;
      #1;
      tests++;
      if ({lo_q, op_ready} !== {32'd10, 1'b0}) begin
         fails++; $display("FAIL b2b_mtlo_held: got LO=%0d ready=%b required 10 0", lo_q, op_ready);
      end
      @(negedge clk); #1;
      tests++;
      if (op_ready !== 1'b1) begin
         fails++; $display("FAIL b2b_mtlo_accept: got %b required 1", op_ready);
      end
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      tests++;
      if ({lo_q, hi_q, div_valid_in} !== {32'd9, 32'd0, 1'b0}) begin
         fails++; $display("FAIL b2b_mtlo: got LO=%0d HI=%0d vin=%b required 9 0 0", lo_q, hi_q, div_valid_in);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      issue(C_DIVU, 32'd100, 32'd7, "rst_divu");
      repeat (2) @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      tests++;
      if ({div_valid_in, hi_q, lo_q, div_src_a, stall} !== {1'b0, 32'd0, 32'd0, 32'd0, 1'b0}) begin
         fails++; $display("FAIL rst_async: got vin=%b HI=%0d LO=%0d a=%0d stall=%b required 0 0 0 0 0",
                           div_valid_in, hi_q, lo_q, div_src_a, stall);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      issue(C_DIVU, 32'd9, 32'd3, "rst_fresh");
      #1;
      tests++;
      if ({div_valid_in, div_src_a, div_src_b} !== {1'b1, 32'd9, 32'd3}) begin
         fails++; $display("FAIL rst_fresh_launch: got vin=%b a=%0d b=%0d required 1 9 3",
                           div_valid_in, div_src_a, div_src_b);
      end
      @(negedge clk);
      div_valid_out = 1'b1; div_hi = 32'd3; div_lo = 32'd0;
      @(negedge clk);
      div_valid_out = 1'b0;
      #1;
      tests++;
      if ({lo_q, hi_q} !== {32'd3, 32'd0}) begin
         fails++; $display("FAIL rst_fresh_result: got LO=%0d HI=%0d required 3 0", lo_q, hi_q);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_divu();
      test_div_signed();
      test_multu();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
